// File: rtl/load_v_arbiter.sv
// load_v_arbiter: shares one load_v vector-tile loader between NUM_REQ requesters.
//   Round-robin grant, one transfer in flight, tile/done pulses routed back to the owner.
//   Optional statistics counters are built when LOAD_V_ARB_STATS_EN is defined.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/addr/len       per-requester request (held until req_ready), packed per index
//   req_ready                1-cycle accept pulse to the granted requester
//   resp_tile, resp_done     1-cycle pulses to the owning requester (tile seen / transfer complete)
//   ld_valid_in/dram_addr/length   command side of load_v
//   ld_tile_out, ld_valid_out      status side of load_v
//   busy, grant_id           activity flag and current/last owner
//   stat_xfers, stat_stall, stat_clr   (LOAD_V_ARB_STATS_EN only) 16-bit saturating counters per requester
module load_v_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 24,
    parameter int LEN_W   = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          resp_tile,
    output logic [NUM_REQ-1:0]          resp_done,
    output logic                        ld_valid_in,
    output logic [ADDR_W-1:0]           ld_dram_addr,
    output logic [LEN_W-1:0]            ld_length,
    input  logic                        ld_tile_out,
    input  logic                        ld_valid_out,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
`ifdef LOAD_V_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]       stat_xfers,
    output logic [NUM_REQ*16-1:0]       stat_stall,
    input  logic                        stat_clr
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    ptr_q;
    // Set when the current grant had len==0: RELEASE then carries its resp_done.
    logic               zero_q;

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [LEN_W-1:0]   len_arr  [NUM_REQ];

    logic               found;
    logic [ID_W-1:0]    gnt_idx;
    logic [LEN_W-1:0]   len_sel;

    logic [NUM_REQ-1:0] ready_d;
    logic [NUM_REQ-1:0] tile_d;
    logic [NUM_REQ-1:0] done_d;
    logic               ldv_d;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        onehot = NUM_REQ'(1) << idx;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign len_arr[i]  = req_len[i*LEN_W +: LEN_W];
    end

    // Round-robin scan starting one past the last owner.
    always_comb begin
        logic [ID_W-1:0] cand;
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign len_sel = len_arr[gnt_idx];

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    // Zero-length requests skip the loader but still take the
                    // RELEASE slot, which keeps the still-high req_valid of the
                    // accepted requester from being granted twice.
                    state_d = (len_sel != '0) ? S_ISSUE : S_RELEASE;
                end
            end
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (ld_valid_out) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic: values loaded into the output registers at the next edge.
    always_comb begin
        ready_d = '0;
        tile_d  = '0;
        done_d  = '0;
        ldv_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ready_d = onehot(gnt_idx);
                    ldv_d   = (len_sel != '0);
                end
            end
            S_WAIT: begin
                if (ld_tile_out)  tile_d = onehot(grant_id);
                if (ld_valid_out) done_d = onehot(grant_id);
            end
            S_RELEASE: begin
                if (zero_q) done_d = onehot(grant_id);
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            zero_q       <= 1'b0;
            grant_id     <= '0;
            ld_dram_addr <= '0;
            ld_length    <= '0;
            ld_valid_in  <= 1'b0;
            req_ready    <= '0;
            resp_tile    <= '0;
            resp_done    <= '0;
            busy         <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_valid_in <= ldv_d;
            req_ready   <= ready_d;
            resp_tile   <= tile_d;
            resp_done   <= done_d;
            busy        <= (state_d != S_IDLE);
            if (state_q == S_IDLE && found) begin
                ptr_q        <= gnt_idx;
                grant_id     <= gnt_idx;
                zero_q       <= (len_sel == '0);
                ld_dram_addr <= addr_arr[gnt_idx];
                ld_length    <= len_sel;
            end
        end
    end

`ifdef LOAD_V_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] xfer_q;
    logic [NUM_REQ-1:0][15:0] stall_q;

    // A transfer counts when its resp_done is registered; a stall is any
    // cycle a requester is asking without seeing its accept pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else if (stat_clr) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done_d[i] && xfer_q[i] != 16'hFFFF) begin
                    xfer_q[i] <= xfer_q[i] + 16'd1;
                end
                if (req_valid[i] && !req_ready[i] && stall_q[i] != 16'hFFFF) begin
                    stall_q[i] <= stall_q[i] + 16'd1;
                end
            end
        end
    end

    assign stat_xfers = xfer_q;
    assign stat_stall = stall_q;
`endif

endmodule
